// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared widths, funct3 width codes and FSM state encoding for
//               the memory-access pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;

    // funct3 codes; bits [1:0] give the width, bit [2] selects zero-extension
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        case (width)
            WIDTH_B: is_misaligned = 1'b0;
            WIDTH_H: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_load_align.sv
// ============================================================================
// Module      : mem_access_load_align
// Description : Selects the addressed byte/halfword lane of a read word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [REG_BUS-1:0] rdata_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [2:0]         funct3_i,
    output logic [REG_BUS-1:0] data_o
);

    logic [REG_BUS-1:0] w_shifted;
    logic               w_sign_b;
    logic               w_sign_h;

    assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};
    assign w_sign_b  = ~funct3_i[2] & w_shifted[7];
    assign w_sign_h  = ~funct3_i[2] & w_shifted[15];

    always_comb begin
        data_o = rdata_i;
        case (funct3_i[1:0])
            WIDTH_B: data_o = {{24{w_sign_b}}, w_shifted[7:0]};
            WIDTH_H: data_o = {{16{w_sign_h}}, w_shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : Memory-access pipeline stage: runs a req/ack data-memory
//               transaction for loads/stores and registers into writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
    import mem_access_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid_i,
    input  logic [REG_BUS-1:0]      ex_alu_result_i,
    input  logic [REG_BUS-1:0]      ex_store_data_i,
    input  logic [2:0]              ex_funct3_i,
    input  logic                    ex_mem_read_i,
    input  logic                    ex_mem_write_i,
    input  logic                    ex_wb_Mem2Reg_i,
    input  logic                    ex_wb_RegWrite_i,
    input  logic [REG_ADDR_BUS-1:0] ex_rd_i,
    output logic                    stall_o,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [REG_BUS-1:0]      dmem_addr_o,
    output logic [3:0]              dmem_be_o,
    output logic [REG_BUS-1:0]      dmem_wdata_o,
    input  logic                    dmem_ack_i,
    input  logic [REG_BUS-1:0]      dmem_rdata_i,
    output logic                    wb_valid_o,
    output logic [REG_BUS-1:0]      mem_read_data_o,
    output logic [REG_BUS-1:0]      alu_result_o,
    output logic                    ctrl_wb_Mem2Reg_o,
    output logic                    ctrl_wb_RegWrite_o,
    output logic [REG_ADDR_BUS-1:0] wb_rd_o,
    output logic                    misalign_o
);

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [REG_BUS-1:0]      addr_q, addr_d;
    logic [3:0]              be_q, be_d;
    logic [REG_BUS-1:0]      wdata_q, wdata_d;
    logic [1:0]              addr_lo_q, addr_lo_d;
    logic [2:0]              funct3_q, funct3_d;
    logic                    m2r_q, m2r_d;
    logic                    rw_q, rw_d;
    logic [REG_ADDR_BUS-1:0] rd_q, rd_d;

    logic                    wb_valid_q, wb_valid_d;
    logic [REG_BUS-1:0]      wb_data_q, wb_data_d;
    logic [REG_BUS-1:0]      wb_alu_q, wb_alu_d;
    logic                    wb_m2r_q, wb_m2r_d;
    logic                    wb_rw_q, wb_rw_d;
    logic [REG_ADDR_BUS-1:0] wb_rd_q, wb_rd_d;
    logic                    misalign_q, misalign_d;

    logic                    w_memop;
    logic                    w_misaligned;
    logic [1:0]              w_addr_lo;
    logic [3:0]              w_be;
    logic [REG_BUS-1:0]      w_wdata;
    logic [REG_BUS-1:0]      w_load_data;

    assign w_memop      = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
    assign w_addr_lo    = ex_alu_result_i[1:0];
    assign w_misaligned = is_misaligned(ex_funct3_i[1:0], w_addr_lo);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_store_data_i;
        case (ex_funct3_i[1:0])
            WIDTH_B: begin
                w_be    = 4'b0001 << w_addr_lo;
                w_wdata = {4{ex_store_data_i[7:0]}};
            end
            WIDTH_H: begin
                w_be    = 4'b0011 << {w_addr_lo[1], 1'b0};
                w_wdata = {2{ex_store_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex_store_data_i;
            end
        endcase
    end

    mem_access_load_align u_load_align (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (w_load_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        addr_lo_d  = addr_lo_q;
        funct3_d   = funct3_q;
        m2r_d      = m2r_q;
        rw_d       = rw_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_alu_d   = wb_alu_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = wb_rw_q;
        wb_rd_d    = wb_rd_q;
        misalign_d = 1'b0;
        stall_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i && (!w_memop || w_misaligned)) begin
                    // Non-memops and misaligned accesses retire without touching memory
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    wb_alu_d   = ex_alu_result_i;
                    wb_m2r_d   = ex_wb_Mem2Reg_i;
                    wb_rw_d    = ex_wb_RegWrite_i & ~w_memop;
                    wb_rd_d    = ex_rd_i;
                    misalign_d = w_memop;
                end else if (w_memop) begin
                    stall_o   = 1'b1;
                    state_d   = ST_BUSY;
                    req_d     = 1'b1;
                    we_d      = ex_mem_write_i;
                    addr_d    = {ex_alu_result_i[REG_BUS-1:2], 2'b00};
                    be_d      = w_be;
                    wdata_d   = w_wdata;
                    addr_lo_d = w_addr_lo;
                    funct3_d  = ex_funct3_i;
                    m2r_d     = ex_wb_Mem2Reg_i;
                    rw_d      = ex_wb_RegWrite_i;
                    rd_d      = ex_rd_i;
                end
            end
            ST_BUSY: begin
                if (dmem_ack_i) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = we_q ? '0 : w_load_data;
                    wb_alu_d   = {addr_q[REG_BUS-1:2], addr_lo_q};
                    wb_m2r_d   = m2r_q;
                    wb_rw_d    = rw_q;
                    wb_rd_d    = rd_q;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            addr_lo_q  <= '0;
            funct3_q   <= '0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_alu_q   <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            addr_lo_q  <= addr_lo_d;
            funct3_q   <= funct3_d;
            m2r_q      <= m2r_d;
            rw_q       <= rw_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_alu_q   <= wb_alu_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req_o         = req_q;
    assign dmem_we_o          = we_q;
    assign dmem_addr_o        = addr_q;
    assign dmem_be_o          = be_q;
    assign dmem_wdata_o       = wdata_q;
    assign wb_valid_o         = wb_valid_q;
    assign mem_read_data_o    = wb_data_q;
    assign alu_result_o       = wb_alu_q;
    assign ctrl_wb_Mem2Reg_o  = wb_m2r_q;
    assign ctrl_wb_RegWrite_o = wb_rw_q;
    assign wb_rd_o            = wb_rd_q;
    assign misalign_o         = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_m2r;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] mem_read_data;
    logic [31:0] alu_result;
    logic        wb_m2r;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic        misalign;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_access u_dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid_i         (ex_valid),
        .ex_alu_result_i    (ex_alu_result),
        .ex_store_data_i    (ex_store_data),
        .ex_funct3_i        (ex_funct3),
        .ex_mem_read_i      (ex_mem_read),
        .ex_mem_write_i     (ex_mem_write),
        .ex_wb_Mem2Reg_i    (ex_m2r),
        .ex_wb_RegWrite_i   (ex_rw),
        .ex_rd_i            (ex_rd),
        .stall_o            (stall),
        .dmem_req_o         (dmem_req),
        .dmem_we_o          (dmem_we),
        .dmem_addr_o        (dmem_addr),
        .dmem_be_o          (dmem_be),
        .dmem_wdata_o       (dmem_wdata),
        .dmem_ack_i         (dmem_ack),
        .dmem_rdata_i       (dmem_rdata),
        .wb_valid_o         (wb_valid),
        .mem_read_data_o    (mem_read_data),
        .alu_result_o       (alu_result),
        .ctrl_wb_Mem2Reg_o  (wb_m2r),
        .ctrl_wb_RegWrite_o (wb_rw),
        .wb_rd_o            (wb_rd),
        .misalign_o         (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                         input logic [2:0] f3, input logic rd_en, input logic wr_en,
                         input logic m2r, input logic rw, input logic [4:0] rd);
        ex_valid      = v;
        ex_alu_result = a;
        ex_store_data = sd;
        ex_funct3     = f3;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_m2r        = m2r;
        ex_rw         = rw;
        ex_rd         = rd;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        // ALU op
        drive(1'b1, 32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        chk("alu_stall", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("alu_result", alu_result, 32'h1234);
        chk("alu_rd", {27'b0, wb_rd}, 32'd5);
        chk("alu_rw", {31'b0, wb_rw}, 32'd1);
        chk("alu_req", {31'b0, dmem_req}, 32'd0);
        tick();
        chk("alu_wb_drop", {31'b0, wb_valid}, 32'd0);

        // LB at 0x103, ack on the third BUSY cycle
        drive(1'b1, 32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
        chk("lb_stall_issue", {31'b0, stall}, 32'd1);
        tick();
        chk("lb_req", {31'b0, dmem_req}, 32'd1);
        chk("lb_we", {31'b0, dmem_we}, 32'd0);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", {28'b0, dmem_be}, 32'h8);
        chk("lb_stall_b1", {31'b0, stall}, 32'd1);
        chk("lb_wb_valid_b1", {31'b0, wb_valid}, 32'd0);
        tick();
        chk("lb_stall_b2", {31'b0, stall}, 32'd1);
        chk("lb_req_b2", {31'b0, dmem_req}, 32'd1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_0000;
        #1;
        chk("lb_stall_ack", {31'b0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("lb_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lb_data", mem_read_data, 32'hFFFF_FF80);
        chk("lb_alu", alu_result, 32'h103);
        chk("lb_rd", {27'b0, wb_rd}, 32'd7);
        chk("lb_m2r", {31'b0, wb_m2r}, 32'd1);
        chk("lb_req_drop", {31'b0, dmem_req}, 32'd0);
        tick();

        // SH at 0x202, one wait cycle
        drive(1'b1, 32'h202, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("sh_stall_issue", {31'b0, stall}, 32'd1);
        tick();
        chk("sh_we", {31'b0, dmem_we}, 32'd1);
        chk("sh_addr", dmem_addr, 32'h200);
        chk("sh_be", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        tick();
        chk("sh_be_hold", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata_hold", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_req_hold", {31'b0, dmem_req}, 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("sh_stall_ack", {31'b0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("sh_data_zero", mem_read_data, 32'd0);
        chk("sh_req_drop", {31'b0, dmem_req}, 32'd0);
        tick();

        // Misaligned LW at 0x06
        drive(1'b1, 32'h6, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("mis_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_rw", {31'b0, wb_rw}, 32'd0);
        chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        tick();
        chk("mis_flag_drop", {31'b0, misalign}, 32'd0);
        chk("mis_wb_drop", {31'b0, wb_valid}, 32'd0);

        // Reset while BUSY, then a late ack
        drive(1'b1, 32'h10, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        chk("rb_req", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("rb_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("rb_wb_valid", {31'b0, wb_valid}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        #1;
        chk("rb_stall_late_ack", {31'b0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("rb_no_wb", {31'b0, wb_valid}, 32'd0);
        chk("rb_no_req", {31'b0, dmem_req}, 32'd0);

        // Back-to-back LHU, zero-wait ack
        drive(1'b1, 32'h302, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
        tick();
        chk("lhu1_req", {31'b0, dmem_req}, 32'd1);
        chk("lhu1_be", {28'b0, dmem_be}, 32'hC);
        chk("lhu1_addr", dmem_addr, 32'h300);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8001_0000;
        #1;
        tick();
        dmem_ack = 1'b0;
        drive(1'b1, 32'h300, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
        chk("lhu1_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lhu1_data", mem_read_data, 32'h0000_8001);
        chk("lhu_gap_req", {31'b0, dmem_req}, 32'd0);
        chk("lhu2_stall_issue", {31'b0, stall}, 32'd1);
        tick();
        chk("lhu2_req", {31'b0, dmem_req}, 32'd1);
        chk("lhu2_be", {28'b0, dmem_be}, 32'h3);
        chk("lhu2_wb_valid_busy", {31'b0, wb_valid}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_FFFE;
        #1;
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("lhu2_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lhu2_data", mem_read_data, 32'h0000_FFFE);
        chk("lhu2_rd", {27'b0, wb_rd}, 32'd6);
        chk("lhu2_req_drop", {31'b0, dmem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
